// File: rtl/atm_pkg.sv
// Shared definitions for the ATM session controller.
// State encoding, operation codes and the fixed account/PIN tables.
package atm_pkg;

  localparam int N_ACC = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_PIN = 3'd1,
    MENU    = 3'd2,
    EXEC    = 3'd3
  } state_t;

  localparam logic [1:0] OP_BALANCE  = 2'd0;
  localparam logic [1:0] OP_WITHDRAW = 2'd1;
  localparam logic [1:0] OP_DEPOSIT  = 2'd2;
  localparam logic [1:0] OP_TRANSFER = 2'd3;

  localparam logic [11:0] ACC_TABLE [N_ACC] = '{
    12'd2178, 12'd2816, 12'd2278, 12'd1034, 12'd1450,
    12'd1990, 12'd3071, 12'd3333, 12'd3761, 12'd4095
  };

  localparam logic [3:0] PIN_TABLE [N_ACC] = '{
    4'd4, 4'd6, 4'd9, 4'd1, 4'd2,
    4'd3, 4'd5, 4'd7, 4'd8, 4'd0
  };

endpackage

// File: rtl/atm_controller_p_if.sv
// Keypad-side request and display-side status bundle
// of the ATM session controller.
interface atm_controller_p_if #(
  parameter int ACC_W = 12,
  parameter int PIN_W = 4,
  parameter int BAL_W = 11
) ();
  logic             card_valid;
  logic [ACC_W-1:0] acc_number;
  logic             pin_valid;
  logic [PIN_W-1:0] pin;
  logic             op_valid;
  logic [1:0]       op_code;
  logic [BAL_W-1:0] amount;
  logic [ACC_W-1:0] dest_acc_number;
  logic             exit;
  logic             day_rollover;
  logic [2:0]       state;
  logic [BAL_W-1:0] balance;
  logic             op_done;
  logic             error;
  logic             locked;
  logic             timeout;

  modport master (
    output card_valid, acc_number, pin_valid, pin,
    output op_valid, op_code, amount, dest_acc_number,
    output exit, day_rollover,
    input  state, balance, op_done, error, locked, timeout
  );

  modport slave (
    input  card_valid, acc_number, pin_valid, pin,
    input  op_valid, op_code, amount, dest_acc_number,
    input  exit, day_rollover,
    output state, balance, op_done, error, locked, timeout
  );
endinterface

// File: rtl/atm_account_lookup.sv
// Parallel match of an account number against the account table;
// first matching entry wins.
module atm_account_lookup
  import atm_pkg::*;
#(
  parameter int N     = N_ACC,
  parameter int ACC_W = 12,
  parameter int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic [ACC_W-1:0] acc,
  output logic             hit,
  output logic [IW-1:0]    idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!hit && acc == ACC_W'(ACC_TABLE[i])) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end
endmodule

// File: rtl/atm_controller_p.sv
// ATM session controller: card/PIN login with lockout, balance table,
// daily withdrawal limit and idle-session timeout.
module atm_controller_p
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS   = N_ACC,
  parameter int ACC_W          = 12,
  parameter int PIN_W          = 4,
  parameter int BAL_W          = 11,
  parameter int INIT_BALANCE   = 500,
  parameter int DAILY_LIMIT    = 1000,
  parameter int MAX_PIN_TRIES  = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic clk,
  input logic rst,
  atm_controller_p_if.slave bus
);
  localparam int IW = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
  localparam int DW = $clog2(DAILY_LIMIT + 1);
  localparam int TW = $clog2(MAX_PIN_TRIES + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  st;
  logic [IW-1:0]           idx;
  logic [BAL_W-1:0]        bal   [NUM_ACCOUNTS];
  logic [DW-1:0]           daily [NUM_ACCOUNTS];
  logic [TW-1:0]           tries [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock;
  logic [CW-1:0]           idle;
  logic [BAL_W-1:0]        bal_o;
  logic                    done_o, err_o, lock_o, tmo_o;

  logic          card_hit, dst_hit;
  logic [IW-1:0] card_idx, dst_idx;

  atm_account_lookup #(.N(NUM_ACCOUNTS), .ACC_W(ACC_W), .IW(IW)) u_card (
    .acc(bus.acc_number), .hit(card_hit), .idx(card_idx)
  );

  atm_account_lookup #(.N(NUM_ACCOUNTS), .ACC_W(ACC_W), .IW(IW)) u_dest (
    .acc(bus.dest_acc_number), .hit(dst_hit), .idx(dst_idx)
  );

  logic [BAL_W-1:0] cur, dst, new_cur;
  logic [DW-1:0]    day_now;
  logic [31:0]      day_sum;
  logic [BAL_W:0]   dep_sum, xfer_sum;
  logic             wd_bad, op_bad, op_err, strobe, pin_ok, last_try;
  logic             tmo_hit;

  always_comb begin
    cur      = bal[idx];
    dst      = bal[dst_idx];
    // A same-cycle rollover is applied before the limit check
    day_now  = bus.day_rollover ? '0 : daily[idx];
    day_sum  = 32'(day_now) + 32'(bus.amount);
    dep_sum  = {1'b0, cur} + {1'b0, bus.amount};
    xfer_sum = {1'b0, dst} + {1'b0, bus.amount};
    wd_bad   = (bus.amount > cur) || (day_sum > 32'(DAILY_LIMIT));
    op_bad   = 1'b0;
    new_cur  = cur;
    unique case (bus.op_code)
      OP_WITHDRAW: begin
        op_bad  = wd_bad;
        new_cur = cur - bus.amount;
      end
      OP_DEPOSIT: begin
        op_bad  = dep_sum[BAL_W];
        new_cur = dep_sum[BAL_W-1:0];
      end
      OP_TRANSFER: begin
        op_bad  = !dst_hit || (dst_idx == idx) || wd_bad || xfer_sum[BAL_W];
        new_cur = cur - bus.amount;
      end
      default: ;
    endcase
    op_err   = op_bad && (bus.amount != '0);
    strobe   = bus.card_valid | bus.pin_valid | bus.op_valid | bus.exit;
    pin_ok   = bus.pin == PIN_W'(PIN_TABLE[idx]);
    last_try = tries[idx] == TW'(MAX_PIN_TRIES - 1);
    tmo_hit  = idle == CW'(TIMEOUT_CYCLES - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      idx    <= '0;
      bal_o  <= '0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      lock_o <= 1'b0;
      tmo_o  <= 1'b0;
      lock   <= '0;
      idle   <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal[i]   <= BAL_W'(INIT_BALANCE);
        daily[i] <= '0;
        tries[i] <= '0;
      end
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      lock_o <= 1'b0;
      tmo_o  <= 1'b0;
      if (bus.day_rollover) begin
        for (int i = 0; i < NUM_ACCOUNTS; i++) daily[i] <= '0;
      end
      unique case (st)
        IDLE: begin
          idle <= '0;
          if (bus.card_valid) begin
            if (card_hit && !lock[card_idx]) begin
              idx <= card_idx;
              st  <= GET_PIN;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        GET_PIN: begin
          if (bus.exit) begin
            idle <= '0;
            st   <= IDLE;
          end else if (bus.pin_valid) begin
            idle <= '0;
            if (pin_ok) begin
              tries[idx] <= '0;
              bal_o      <= cur;
              st         <= MENU;
            end else begin
              tries[idx] <= tries[idx] + 1'b1;
              err_o      <= 1'b1;
              if (last_try) begin
                lock[idx] <= 1'b1;
                lock_o    <= 1'b1;
                st        <= IDLE;
              end
            end
          end else if (strobe) begin
            idle <= '0;
          end else if (tmo_hit) begin
            idle  <= '0;
            tmo_o <= 1'b1;
            st    <= IDLE;
          end else begin
            idle <= idle + 1'b1;
          end
        end
        MENU: begin
          if (bus.exit) begin
            idle <= '0;
            st   <= IDLE;
          end else if (bus.op_valid) begin
            idle   <= '0;
            st     <= EXEC;
            done_o <= 1'b1;
            err_o  <= op_err;
            bal_o  <= op_err ? cur : new_cur;
            if (!op_err) begin
              bal[idx] <= new_cur;
              if (bus.op_code == OP_WITHDRAW) daily[idx] <= DW'(day_sum);
              if (bus.op_code == OP_TRANSFER) begin
                daily[idx]   <= DW'(day_sum);
                bal[dst_idx] <= xfer_sum[BAL_W-1:0];
              end
            end
          end else if (strobe) begin
            idle <= '0;
          end else if (tmo_hit) begin
            idle  <= '0;
            tmo_o <= 1'b1;
            st    <= IDLE;
          end else begin
            idle <= idle + 1'b1;
          end
        end
        EXEC: begin
          idle <= '0;
          st   <= bus.exit ? IDLE : MENU;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.state   = st;
  assign bus.balance = bal_o;
  assign bus.op_done = done_o;
  assign bus.error   = err_o;
  assign bus.locked  = lock_o;
  assign bus.timeout = tmo_o;
endmodule

// File: tb/tb_atm_controller_p.sv
// Directed bench for atm_controller_p with a 500 daily limit
// and a 16-cycle idle timeout.
module tb_atm_controller_p;
  import atm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  atm_controller_p_if #(.ACC_W(12), .PIN_W(4), .BAL_W(11)) bus ();

  atm_controller_p #(
    .NUM_ACCOUNTS(10), .ACC_W(12), .PIN_W(4), .BAL_W(11),
    .INIT_BALANCE(500), .DAILY_LIMIT(500),
    .MAX_PIN_TRIES(3), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic card(input int acc);
    bus.card_valid = 1'b1;
    bus.acc_number = 12'(acc);
    tick();
    bus.card_valid = 1'b0;
  endtask

  task automatic enter_pin(input int p);
    bus.pin_valid = 1'b1;
    bus.pin       = 4'(p);
    tick();
    bus.pin_valid = 1'b0;
  endtask

  task automatic op(input string tag, input logic [1:0] c, input int a,
                    input int d, input logic roll, input int exp_bal,
                    input logic exp_err);
    bus.op_valid        = 1'b1;
    bus.op_code         = c;
    bus.amount          = 11'(a);
    bus.dest_acc_number = 12'(d);
    bus.day_rollover    = roll;
    tick();
    bus.op_valid     = 1'b0;
    bus.day_rollover = 1'b0;
    chk({tag, "_done"}, 32'(bus.op_done), 32'd1);
    chk({tag, "_err"},  32'(bus.error),   32'(exp_err));
    chk({tag, "_bal"},  32'(bus.balance), 32'(exp_bal));
    tick();
    chk({tag, "_menu"}, 32'(bus.state), 32'(MENU));
  endtask

  initial begin
    bus.card_valid = 0; bus.acc_number = '0;
    bus.pin_valid = 0; bus.pin = '0;
    bus.op_valid = 0; bus.op_code = '0; bus.amount = '0;
    bus.dest_acc_number = '0; bus.exit = 0; bus.day_rollover = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_state", 32'(bus.state), 32'(IDLE));
    chk("rst_bal", 32'(bus.balance), 32'd0);
    chk("rst_done", 32'(bus.op_done), 32'd0);
    chk("rst_err", 32'(bus.error), 32'd0);

    card(1234);
    chk("badcard_err", 32'(bus.error), 32'd1);
    chk("badcard_idle", 32'(bus.state), 32'(IDLE));

    card(2178);
    chk("card_getpin", 32'(bus.state), 32'(GET_PIN));
    chk("card_err", 32'(bus.error), 32'd0);
    enter_pin(4);
    chk("pin_menu", 32'(bus.state), 32'(MENU));
    chk("pin_bal", 32'(bus.balance), 32'd500);

    op("wd100", OP_WITHDRAW, 100, 0, 1'b0, 400, 1'b0);
    op("wd2500", OP_WITHDRAW, 2500, 0, 1'b0, 400, 1'b1);
    op("dep1700", OP_DEPOSIT, 1700, 0, 1'b0, 400, 1'b1);
    op("dep500", OP_DEPOSIT, 500, 0, 1'b0, 900, 1'b0);
    op("xf50", OP_TRANSFER, 50, 2816, 1'b0, 850, 1'b0);
    op("xfself", OP_TRANSFER, 10, 2178, 1'b0, 850, 1'b1);
    op("xfunk", OP_TRANSFER, 10, 1234, 1'b0, 850, 1'b1);

    bus.exit = 1'b1; tick(); bus.exit = 1'b0;
    chk("exit_idle", 32'(bus.state), 32'(IDLE));
    chk("exit_hold_bal", 32'(bus.balance), 32'd850);

    card(2816); enter_pin(6);
    chk("login2816_bal", 32'(bus.balance), 32'd550);

    bus.exit = 1'b1; bus.op_valid = 1'b1;
    bus.op_code = OP_WITHDRAW; bus.amount = 11'd100;
    tick();
    bus.exit = 1'b0; bus.op_valid = 1'b0;
    chk("exitop_idle", 32'(bus.state), 32'(IDLE));
    chk("exitop_done", 32'(bus.op_done), 32'd0);
    card(2816); enter_pin(6);
    chk("exitop_bal", 32'(bus.balance), 32'd550);

    op("dep1000", OP_DEPOSIT, 1000, 0, 1'b0, 1550, 1'b0);
    op("lim_wd1", OP_WITHDRAW, 300, 0, 1'b0, 1250, 1'b0);
    op("lim_wd2", OP_WITHDRAW, 300, 0, 1'b0, 1250, 1'b1);
    bus.day_rollover = 1'b1; tick(); bus.day_rollover = 1'b0;
    op("lim_wd3", OP_WITHDRAW, 300, 0, 1'b0, 950, 1'b0);
    op("roll_same", OP_WITHDRAW, 300, 0, 1'b1, 650, 1'b0);
    op("wd0", OP_WITHDRAW, 0, 0, 1'b0, 650, 1'b0);

    for (int i = 0; i < 15; i++) tick();
    chk("tmo_early", 32'(bus.timeout), 32'd0);
    chk("tmo_early_st", 32'(bus.state), 32'(MENU));
    tick();
    chk("tmo_pulse", 32'(bus.timeout), 32'd1);
    chk("tmo_idle", 32'(bus.state), 32'(IDLE));
    tick();
    chk("tmo_1cyc", 32'(bus.timeout), 32'd0);

    card(2278);
    enter_pin(3);
    chk("pin1_err", 32'(bus.error), 32'd1);
    chk("pin1_lock", 32'(bus.locked), 32'd0);
    enter_pin(3);
    chk("pin2_err", 32'(bus.error), 32'd1);
    chk("pin2_st", 32'(bus.state), 32'(GET_PIN));
    enter_pin(3);
    chk("pin3_err", 32'(bus.error), 32'd1);
    chk("pin3_lock", 32'(bus.locked), 32'd1);
    chk("pin3_idle", 32'(bus.state), 32'(IDLE));
    card(2278);
    chk("locked_err", 32'(bus.error), 32'd1);
    chk("locked_idle", 32'(bus.state), 32'(IDLE));

    card(2178); enter_pin(4);
    chk("relog2178", 32'(bus.balance), 32'd850);
    bus.op_valid = 1'b1; bus.op_code = OP_WITHDRAW;
    bus.amount = 11'd100; rst = 1'b1;
    tick();
    bus.op_valid = 1'b0; rst = 1'b0;
    chk("midrst_st", 32'(bus.state), 32'(IDLE));
    chk("midrst_bal", 32'(bus.balance), 32'd0);
    chk("midrst_done", 32'(bus.op_done), 32'd0);
    card(2178); enter_pin(4);
    chk("post_rst_bal", 32'(bus.balance), 32'd500);
    bus.exit = 1'b1; tick(); bus.exit = 1'b0;
    card(2278);
    chk("unlock_rst", 32'(bus.state), 32'(GET_PIN));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
